// File: rtl/vx_fpu_req_tracker_if.sv
// Bundle of the issue-side, FPU-side and commit-side signals of the FPU request tracker.
// The master modport is the tracker itself; slave is the surrounding environment.
interface vx_fpu_req_tracker_if #(
  parameter int NUM_LANES  = 4,
  parameter int XLEN       = 32,
  parameter int META_WIDTH = 40,
  parameter int REQ_WIDTH  = 110,
  parameter int NUM_TAGS   = 8
);
  localparam int TAG_WIDTH = $clog2(NUM_TAGS);
  localparam int RES_WIDTH = NUM_LANES * XLEN;

  logic                  req_valid;
  logic                  req_ready;
  logic [REQ_WIDTH-1:0]  req_payload;
  logic [META_WIDTH-1:0] req_meta;

  logic                  fpu_valid_in;
  logic                  fpu_ready_in;
  logic [REQ_WIDTH-1:0]  fpu_payload;
  logic [TAG_WIDTH-1:0]  fpu_tag_in;

  logic                  fpu_valid_out;
  logic                  fpu_ready_out;
  logic [RES_WIDTH-1:0]  fpu_result;
  logic                  fpu_has_fflags;
  logic [4:0]            fpu_fflags;
  logic [TAG_WIDTH-1:0]  fpu_tag_out;

  logic                  commit_valid;
  logic                  commit_ready;
  logic [META_WIDTH-1:0] commit_meta;
  logic [RES_WIDTH-1:0]  commit_result;
  logic                  commit_has_fflags;
  logic [4:0]            commit_fflags;

  logic                  fflags_clr;
  logic [4:0]            fflags_sticky;
  logic [TAG_WIDTH:0]    pending_count;
  logic                  rsp_err;

  modport master (
    input  req_valid, req_payload, req_meta,
    output req_ready,
    output fpu_valid_in, fpu_payload, fpu_tag_in,
    input  fpu_ready_in,
    input  fpu_valid_out, fpu_result, fpu_has_fflags, fpu_fflags, fpu_tag_out,
    output fpu_ready_out,
    output commit_valid, commit_meta, commit_result, commit_has_fflags, commit_fflags,
    input  commit_ready,
    input  fflags_clr,
    output fflags_sticky, pending_count, rsp_err
  );

  modport slave (
    output req_valid, req_payload, req_meta,
    input  req_ready,
    input  fpu_valid_in, fpu_payload, fpu_tag_in,
    output fpu_ready_in,
    output fpu_valid_out, fpu_result, fpu_has_fflags, fpu_fflags, fpu_tag_out,
    input  fpu_ready_out,
    input  commit_valid, commit_meta, commit_result, commit_has_fflags, commit_fflags,
    output commit_ready,
    output fflags_clr,
    input  fflags_sticky, pending_count, rsp_err
  );
endinterface

// File: rtl/vx_fpu_req_tracker.sv
// Tag allocator and response matcher sitting between the issue stage and an out-of-order FPU core.
// Responses are reordered back to their metadata by tag and presented through a one-entry commit register.
module vx_fpu_req_tracker #(
  parameter int NUM_LANES  = 4,
  parameter int XLEN       = 32,
  parameter int META_WIDTH = 40,
  parameter int REQ_WIDTH  = 110,
  parameter int NUM_TAGS   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vx_fpu_req_tracker_if.master bus
);
  localparam int TAG_WIDTH = $clog2(NUM_TAGS);
  localparam int RES_WIDTH = NUM_LANES * XLEN;
  localparam logic [TAG_WIDTH:0]  CNT_ONE = (TAG_WIDTH+1)'(1);
  localparam logic [NUM_TAGS-1:0] TAG_ONE = NUM_TAGS'(1);

  logic [NUM_TAGS-1:0]   pending;
  logic [NUM_TAGS-1:0]   pending_set;
  logic [NUM_TAGS-1:0]   pending_clr;
  logic [META_WIDTH-1:0] meta_mem [NUM_TAGS];
  logic [TAG_WIDTH-1:0]  alloc_tag;
  logic                  full;

  logic [TAG_WIDTH:0]    count_q;
  logic                  commit_valid_q;
  logic [META_WIDTH-1:0] commit_meta_q;
  logic [RES_WIDTH-1:0]  commit_result_q;
  logic                  commit_has_fflags_q;
  logic [4:0]            commit_fflags_q;
  logic [4:0]            sticky_q;
  logic                  rsp_err_q;

  logic req_fire;
  logic rsp_ready;
  logic rsp_fire;
  logic rsp_hit;
  logic rsp_miss;
  logic commit_fire;
  logic accumulate;

  // Lowest-index free tag wins; scanning downward lets the last assignment be the lowest.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!pending[i]) alloc_tag = TAG_WIDTH'(i);
    end
  end

  assign full = &pending;

  assign bus.fpu_valid_in = bus.req_valid & ~full;
  assign bus.req_ready    = bus.fpu_ready_in & ~full;
  assign bus.fpu_tag_in   = alloc_tag;
  assign bus.fpu_payload  = bus.req_payload;

  assign req_fire    = bus.req_valid & bus.req_ready;
  assign rsp_ready   = ~commit_valid_q | bus.commit_ready;
  assign rsp_fire    = bus.fpu_valid_out & rsp_ready;
  assign rsp_hit     = rsp_fire & pending[bus.fpu_tag_out];
  assign rsp_miss    = rsp_fire & ~pending[bus.fpu_tag_out];
  assign commit_fire = commit_valid_q & bus.commit_ready;
  assign accumulate  = commit_fire & commit_has_fflags_q;

  assign pending_set = req_fire ? (TAG_ONE << alloc_tag) : '0;
  assign pending_clr = rsp_hit ? (TAG_ONE << bus.fpu_tag_out) : '0;

  assign bus.fpu_ready_out     = rsp_ready;
  assign bus.commit_valid      = commit_valid_q;
  assign bus.commit_meta       = commit_meta_q;
  assign bus.commit_result     = commit_result_q;
  assign bus.commit_has_fflags = commit_has_fflags_q;
  assign bus.commit_fflags     = commit_fflags_q;
  assign bus.fflags_sticky     = sticky_q;
  assign bus.pending_count     = count_q;
  assign bus.rsp_err           = rsp_err_q;

  // A set tag and a cleared tag can never collide: allocation only picks clear bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      count_q <= '0;
    end else begin
      pending <= (pending & ~pending_clr) | pending_set;
      if (req_fire && !rsp_hit) begin
        count_q <= count_q + CNT_ONE;
      end else if (!req_fire && rsp_hit) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) meta_mem[alloc_tag] <= bus.req_meta;
  end

  // One-entry commit pipe: reload on a matched response, otherwise drain on commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid_q      <= 1'b0;
      commit_meta_q       <= '0;
      commit_result_q     <= '0;
      commit_has_fflags_q <= 1'b0;
      commit_fflags_q     <= '0;
    end else if (rsp_hit) begin
      commit_valid_q      <= 1'b1;
      commit_meta_q       <= meta_mem[bus.fpu_tag_out];
      commit_result_q     <= bus.fpu_result;
      commit_has_fflags_q <= bus.fpu_has_fflags;
      commit_fflags_q     <= bus.fpu_fflags;
    end else if (commit_fire) begin
      commit_valid_q      <= 1'b0;
    end
  end

  // A clear that coincides with an accumulating commit keeps only that commit's flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (bus.fflags_clr) begin
        sticky_q <= accumulate ? commit_fflags_q : 5'b0;
      end else if (accumulate) begin
        sticky_q <= sticky_q | commit_fflags_q;
      end
      if (rsp_miss) rsp_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vx_fpu_req_tracker.sv
// Bench for vx_fpu_req_tracker: allocation table, scoreboarded commits and hand-written corner sequences.
module tb_vx_fpu_req_tracker;
  localparam int NL   = 4;
  localparam int XL   = 32;
  localparam int MW   = 40;
  localparam int RW   = 110;
  localparam int NT   = 8;
  localparam int TW   = 3;
  localparam int RESW = NL * XL;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  vx_fpu_req_tracker_if #(.NUM_LANES(NL), .XLEN(XL), .META_WIDTH(MW), .REQ_WIDTH(RW), .NUM_TAGS(NT)) bus();

  vx_fpu_req_tracker #(.NUM_LANES(NL), .XLEN(XL), .META_WIDTH(MW), .REQ_WIDTH(RW), .NUM_TAGS(NT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic          rv;
    logic          fri;
    logic          exp_ready;
    logic          exp_fvalid;
    logic [TW-1:0] exp_tag;
    logic [TW:0]   exp_count;
  } vec_t;

  typedef struct packed {
    logic [MW-1:0]   meta;
    logic [RESW-1:0] res;
    logic            has;
    logic [4:0]      fl;
  } exp_t;

  vec_t          vecs [11];
  exp_t          sb [$];
  logic [NT-1:0] mp;
  logic [NT-1:0] np;
  logic [MW-1:0] mm [NT];
  exp_t          e;
  logic [RESW-1:0] res0;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] lowestFree(input logic [NT-1:0] p);
    logic found;
    found = 1'b0;
    lowestFree = '0;
    for (int i = 0; i < NT; i++) begin
      if (!found && !p[i]) begin
        lowestFree = TW'(i);
        found = 1'b1;
      end
    end
  endfunction

  // Reference model of the pending pool plus the commit scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      mp = '0;
      sb.delete();
    end else begin
      np = mp;
      if (bus.commit_valid && bus.commit_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_commit actual=meta %0h required=no commit", bus.commit_meta);
        end else begin
          e = sb.pop_front();
          checkOutput("commit_data",
                      {bus.commit_meta, bus.commit_result, bus.commit_has_fflags, bus.commit_fflags}, e);
        end
      end
      if (bus.fpu_valid_out && bus.fpu_ready_out && mp[bus.fpu_tag_out]) begin
        sb.push_back('{meta: mm[bus.fpu_tag_out], res: bus.fpu_result,
                       has: bus.fpu_has_fflags, fl: bus.fpu_fflags});
        np[bus.fpu_tag_out] = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) begin
        checkOutput("alloc_tag", bus.fpu_tag_in, lowestFree(mp));
        np[lowestFree(mp)] = 1'b1;
        mm[lowestFree(mp)] = bus.req_meta;
      end
      mp = np;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setVec(input int k, input logic rv, input logic fri, input logic er, input logic ev,
                        input int tag, input int cnt);
    vecs[k].rv         = rv;
    vecs[k].fri        = fri;
    vecs[k].exp_ready  = er;
    vecs[k].exp_fvalid = ev;
    vecs[k].exp_tag    = TW'(tag);
    vecs[k].exp_count  = (TW+1)'(cnt);
  endtask

  task automatic applyStimulus(input vec_t v, input int k);
    bus.req_valid    = v.rv;
    bus.fpu_ready_in = v.fri;
    bus.req_meta     = MW'(32'hE000 + k);
    bus.req_payload  = RW'({$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic issueReqs(input int n, input logic [MW-1:0] base);
    for (int i = 0; i < n; i++) begin
      cycle();
      bus.req_valid   = 1'b1;
      bus.req_meta    = base + MW'(i);
      bus.req_payload = RW'({$urandom, $urandom, $urandom, $urandom});
    end
    cycle();
    bus.req_valid = 1'b0;
  endtask

  task automatic sendRsp(input int tag, input logic has, input logic [4:0] fl);
    cycle();
    bus.fpu_valid_out  = 1'b1;
    bus.fpu_tag_out    = TW'(tag);
    bus.fpu_has_fflags = has;
    bus.fpu_fflags     = fl;
    bus.fpu_result     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic doReset();
    cycle();
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.fpu_valid_out = 1'b0;
    bus.fflags_clr = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    bus.fpu_ready_in = 1'b1;
    bus.commit_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_payload    = '0;
    bus.req_meta       = '0;
    bus.fpu_ready_in   = 1'b1;
    bus.fpu_valid_out  = 1'b0;
    bus.fpu_result     = '0;
    bus.fpu_has_fflags = 1'b0;
    bus.fpu_fflags     = '0;
    bus.fpu_tag_out    = '0;
    bus.commit_ready   = 1'b1;
    bus.fflags_clr     = 1'b0;

    cycle();
    #2;
    checkOutput("reset_count", bus.pending_count, 0);
    checkOutput("reset_commit_valid", bus.commit_valid, 0);
    checkOutput("reset_commit_meta", bus.commit_meta, 0);
    checkOutput("reset_sticky", bus.fflags_sticky, 0);
    checkOutput("reset_rsp_err", bus.rsp_err, 0);
    cycle();
    reset_n = 1'b1;

    // Allocation table: stalled FPU, ready without valid, eight fills, then full.
    setVec(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    setVec(1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) setVec(2 + i, 1'b1, 1'b1, 1'b1, 1'b1, i, i);
    setVec(10, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8);
    for (int k = 0; k < 11; k++) begin
      cycle();
      applyStimulus(vecs[k], k);
      #2;
      checkOutput($sformatf("tbl%0d_req_ready", k), bus.req_ready, vecs[k].exp_ready);
      checkOutput($sformatf("tbl%0d_fpu_valid", k), bus.fpu_valid_in, vecs[k].exp_fvalid);
      checkOutput($sformatf("tbl%0d_count", k), bus.pending_count, vecs[k].exp_count);
      checkOutput($sformatf("tbl%0d_payload", k), bus.fpu_payload, bus.req_payload);
      if (vecs[k].exp_ready) checkOutput($sformatf("tbl%0d_tag", k), bus.fpu_tag_in, vecs[k].exp_tag);
    end

    // Free tag 3 while full: stays full this cycle, tag 3 reusable next cycle.
    sendRsp(3, 1'b0, 5'b0);
    #2;
    checkOutput("free_same_cycle_full", bus.req_ready, 0);
    checkOutput("free_rsp_ready", bus.fpu_ready_out, 1);
    cycle();
    bus.fpu_valid_out = 1'b0;
    #2;
    checkOutput("reuse_req_ready", bus.req_ready, 1);
    checkOutput("reuse_tag", bus.fpu_tag_in, 3);
    checkOutput("reuse_count_before", bus.pending_count, 7);
    checkOutput("reuse_commit_valid", bus.commit_valid, 1);
    cycle();
    bus.req_valid = 1'b0;
    #2;
    checkOutput("reuse_count_after", bus.pending_count, 8);

    // Out-of-order responses 2,0,1.
    doReset();
    issueReqs(3, MW'(40'hA0));
    sendRsp(2, 1'b0, 5'b0);
    sendRsp(0, 1'b0, 5'b0);
    #2;
    checkOutput("ooo_first_meta", bus.commit_meta, 40'hA2);
    sendRsp(1, 1'b0, 5'b0);
    cycle();
    bus.fpu_valid_out = 1'b0;
    cycle();
    cycle();
    #2;
    checkOutput("ooo_count_zero", bus.pending_count, 0);
    checkOutput("ooo_drained", bus.commit_valid, 0);

    // Commit backpressure.
    doReset();
    bus.commit_ready = 1'b0;
    issueReqs(2, MW'(40'hB0));
    sendRsp(0, 1'b0, 5'b0);
    res0 = bus.fpu_result;
    sendRsp(1, 1'b0, 5'b0);
    #2;
    checkOutput("bp_commit_valid", bus.commit_valid, 1);
    checkOutput("bp_rsp_blocked", bus.fpu_ready_out, 0);
    checkOutput("bp_meta", bus.commit_meta, 40'hB0);
    cycle();
    #2;
    checkOutput("bp_meta_stable", bus.commit_meta, 40'hB0);
    checkOutput("bp_result_stable", bus.commit_result, res0);
    checkOutput("bp_still_blocked", bus.fpu_ready_out, 0);
    cycle();
    bus.commit_ready = 1'b1;
    #2;
    checkOutput("bp_rsp_unblocked", bus.fpu_ready_out, 1);
    cycle();
    bus.fpu_valid_out = 1'b0;
    #2;
    checkOutput("bp_second_valid", bus.commit_valid, 1);
    checkOutput("bp_second_meta", bus.commit_meta, 40'hB1);
    cycle();
    #2;
    checkOutput("bp_drained", bus.commit_valid, 0);

    // Sticky flag accumulation and clear.
    doReset();
    issueReqs(4, MW'(40'hD0));
    sendRsp(0, 1'b1, 5'b00001);
    sendRsp(1, 1'b1, 5'b10000);
    sendRsp(2, 1'b0, 5'b01000);
    cycle();
    bus.fpu_valid_out = 1'b0;
    cycle();
    cycle();
    #2;
    checkOutput("sticky_accum", bus.fflags_sticky, 5'b10001);
    sendRsp(3, 1'b1, 5'b00100);
    cycle();
    bus.fpu_valid_out = 1'b0;
    bus.fflags_clr = 1'b1;
    cycle();
    bus.fflags_clr = 1'b0;
    #2;
    checkOutput("sticky_clr_with_commit", bus.fflags_sticky, 5'b00100);
    cycle();
    bus.fflags_clr = 1'b1;
    cycle();
    bus.fflags_clr = 1'b0;
    #2;
    checkOutput("sticky_clr_alone", bus.fflags_sticky, 5'b00000);

    // Response for a tag that is not pending.
    checkOutput("err_before", bus.rsp_err, 0);
    sendRsp(5, 1'b1, 5'b11111);
    #2;
    checkOutput("err_rsp_consumed", bus.fpu_ready_out, 1);
    cycle();
    bus.fpu_valid_out = 1'b0;
    #2;
    checkOutput("err_no_commit", bus.commit_valid, 0);
    checkOutput("err_set", bus.rsp_err, 1);
    checkOutput("err_count", bus.pending_count, 0);
    repeat (3) cycle();
    #2;
    checkOutput("err_sticky", bus.rsp_err, 1);

    // Asynchronous reset mid-operation.
    bus.commit_ready = 1'b0;
    issueReqs(5, MW'(40'hF0));
    sendRsp(0, 1'b0, 5'b0);
    cycle();
    bus.fpu_valid_out = 1'b0;
    #2;
    checkOutput("pre_reset_count", bus.pending_count, 4);
    checkOutput("pre_reset_commit", bus.commit_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_count", bus.pending_count, 0);
    checkOutput("async_commit_valid", bus.commit_valid, 0);
    checkOutput("async_commit_meta", bus.commit_meta, 0);
    checkOutput("async_rsp_err", bus.rsp_err, 0);
    cycle();
    cycle();
    reset_n = 1'b1;
    bus.commit_ready = 1'b1;
    cycle();
    bus.req_valid = 1'b1;
    bus.req_meta  = MW'(40'h77);
    #2;
    checkOutput("post_reset_ready", bus.req_ready, 1);
    checkOutput("post_reset_tag", bus.fpu_tag_in, 0);
    cycle();
    bus.req_valid = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vx_fpu_req_tracker.md
Name: vx_fpu_req_tracker

Overview:
- Initiator-side companion to the FPU wrapper.
- Accepts FPU requests from the issue stage, allocates a tag from a free pool, and stores per-request metadata in a tag-indexed table.
- Forwards each request to the FPU core with its allocated tag. Matches out-of-order responses back to their metadata by tag, frees the tag, and presents a registered commit.
- Accumulates sticky FP exception flags for the CSR unit.

Parameters:
- NUM_LANES, 4, lanes per request.
- XLEN, 32, lane data width.
- META_WIDTH, 40, opaque per-request metadata (wid, PC, rd, tmask) returned on commit.
- REQ_WIDTH, 110, opaque request payload (op_type, fmt, frm, operands) passed through to the FPU.
- NUM_TAGS, 8, outstanding request capacity; power of two, at least 2.
- TAG_WIDTH, log2(NUM_TAGS), derived; not overridable.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  issue request valid.
- req_ready  out  1  issue request accepted.
- req_payload  in  REQ_WIDTH  request payload.
- req_meta  in  META_WIDTH  request metadata.
- fpu_valid_in  out  1  request to FPU valid.
- fpu_ready_in  in  1  FPU can accept.
- fpu_payload  out  REQ_WIDTH  equals req_payload.
- fpu_tag_in  out  TAG_WIDTH  allocated tag.
- fpu_valid_out  in  1  FPU response valid.
- fpu_ready_out  out  1  response accepted.
- fpu_result  in  NUM_LANES*XLEN  response data.
- fpu_has_fflags  in  1  response carries flags.
- fpu_fflags  in  5  NV,DZ,OF,UF,NX.
- fpu_tag_out  in  TAG_WIDTH  response tag.
- commit_valid  out  1  commit valid.
- commit_ready  in  1  commit accepted.
- commit_meta  out  META_WIDTH  metadata of committed request.
- commit_result  out  NUM_LANES*XLEN  result.
- commit_has_fflags  out  1  flags valid.
- commit_fflags  out  5  per-op flags.
- fflags_clr  in  1  clear sticky flags.
- fflags_sticky  out  5  OR of committed flags since the last clear.
- pending_count  out  TAG_WIDTH+1  outstanding requests.
- rsp_err  out  1  sticky: response arrived for a non-pending tag.

Behaviour:
- Reset (async, reset_n=0):
  - pending bitmap=0, pending_count=0.
  - commit_valid=0, commit_* data=0.
  - fflags_sticky=0, rsp_err=0.
  - Meta table is not reset.
- Allocation:
  - full = all pending bits set.
  - alloc tag = lowest-index clear pending bit.
  - fpu_valid_in = req_valid & !full.
  - req_ready = fpu_ready_in & !full.
  - fpu_tag_in = alloc tag; fpu_payload = req_payload.
  - Zero-latency combinational path; req_ready must not depend on req_valid.
- Request fire (req_valid & req_ready): meta[tag] <= req_meta; pending[tag] <= 1.
- Response acceptance: fpu_ready_out = !commit_valid | commit_ready (one-entry pipe register).
- Response fire (fpu_valid_out & fpu_ready_out):
  - If pending[fpu_tag_out]=1: capture meta[tag], result, has_fflags, fflags into the commit register; commit_valid <= 1; clear pending[tag].
  - If pending[fpu_tag_out]=0: response is consumed and dropped, no commit, rsp_err <= 1 (cleared only by reset).
- Tag reuse: a freed tag is allocatable from the next cycle. The same-cycle allocation uses the pre-update bitmap, so full persists for that cycle.
- Same-cycle request fire and response free: pending_count unchanged, both bitmap updates applied.
- Commit fire with no new response: commit_valid <= 0.
- Commit register holds stable while commit_valid & !commit_ready.
- Sticky flags:
  - On commit fire with commit_has_fflags: fflags_sticky |= commit_fflags.
  - fflags_clr alone: fflags_sticky <= 0.
  - fflags_clr with simultaneous accumulating commit: fflags_sticky <= commit_fflags.
- Latency: request combinational to FPU; response to commit_valid is 1 cycle.
- Throughput: 1 request and 1 commit per cycle.

Test Plan:
- Issue 8 back-to-back requests with fpu_ready_in=1 and no responses -> tags 0..7 in order, pending_count=8, req_ready=0 on the 9th. Respond tag 3 -> next cycle a request receives tag 3.
- Out-of-order responses for tags 2,0,1 with meta 0xA2,0xA0,0xA1 -> commits in arrival order carrying meta 0xA2, 0xA0, 0xA1 with matching results; pending_count returns to 0.
- Hold commit_ready=0 with a commit pending and a second response valid -> fpu_ready_out=0 and commit data stable. Raise commit_ready -> second response commits the following cycle.
- Commit fflags 5'b00001 then 5'b10000 (has_fflags=1), then one with has_fflags=0 and flags 5'b01000 -> fflags_sticky=5'b10001. Pulse fflags_clr with a commit of 5'b00100 -> sticky=5'b00100.
- Response with tag 5 while tag 5 is not pending -> consumed, no commit_valid, rsp_err=1 and stays 1.
- Assert reset_n=0 mid-operation with 4 pending and commit_valid=1 -> outputs cleared immediately (asynchronous); after release the first request receives tag 0.
